uart_ack_transmitter: RTL and testbench
=======================================

// Module: uart_ack_transmitter
// PURPOSE
//  Sender end of the external-communication UART link. Serialises one DATA_WIDTH word on tx,
//  then listens on rx for the ACK byte. Retransmits the word on ACK timeout.
//  Reports done on ACK, or fail once retries are exhausted.
//  Sits between the ext-com controller and GPIO (send-data wire out, send-ack wire in).
// PARAMETERS
//  CLK_FREQ          50_000_000  system clock in Hz
//  BAUD_RATE         230400      bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer, 217)
//  DATA_WIDTH        8           word and ACK frame payload width
//  RETRANSMIT_COUNT  5           retransmissions after the first frame (max 1+N frames)
//  ACK_TIMEOUT       1           ACK wait window in ms; TIMEOUT_CLKS = CLK_FREQ/1000*ACK_TIMEOUT
//  ACK_BYTE          8'b11001100 payload that acknowledges receipt
// PORTS
//  clk      in   1           system clock; all logic on posedge
//  rst      in   1           synchronous, active-high reset
//  start    in   1           request to send data_in; honoured only while ready=1
//  data_in  in   DATA_WIDTH  word to send; captured on the accepted start cycle
//  ready    out  1           idle, can accept start
//  done     out  1           1-cycle pulse: ACK received
//  fail     out  1           1-cycle pulse: all attempts timed out
//  tx       out  1           UART line out, idle high
//  rx       in   1           UART line in (ACK), asynchronous
// BEHAVIOUR
//  Reset (rst=1 at posedge): tx=1, ready=1, done=0, fail=0; all FSMs idle, counters 0.
//  Reset at any point aborts: tx=1 from the next cycle, no done/fail pulse.
//  TX FSM: IDLE->START->DATA->STOP->WAIT_ACK->(IDLE | START).
//   IDLE: ready=1. A start at a posedge latches data_in, clears attempts, goes to START.
//    ready=0 from the next cycle.
//   START: tx=0 for CLKS_PER_BIT cycles. DATA: DATA_WIDTH bits, LSB first, CLKS_PER_BIT each.
//   STOP: tx=1 for CLKS_PER_BIT cycles; attempts+1, then WAIT_ACK with timeout counter=0.
//   WAIT_ACK: timeout counter increments every cycle.
//    ACK_BYTE frame received: done=1 for one cycle, then IDLE.
//    counter==TIMEOUT_CLKS-1 with RX idle: if attempts<=RETRANSMIT_COUNT, go to START and
//     resend the latched word unchanged; else fail=1 for one cycle, then IDLE.
//   start while ready=0 is ignored; data_in changes after acceptance have no effect.
//  RX path: 2-flop synchroniser on rx; enabled only in WAIT_ACK (rx ignored otherwise).
//   R_IDLE: falling edge -> R_START. R_START: resample at CLKS_PER_BIT/2.
//    Still 0: R_DATA. 1: false start, return to R_IDLE.
//   R_DATA: sample mid-bit, LSB first. R_STOP: mid-bit sample must be 1.
//    Framing error (stop=0) -> frame discarded.
//   Payload != ACK_BYTE -> discarded; keep waiting, timeout counter not reset.
//  Timeout expiring during an in-progress RX frame is deferred to frame end.
//   If that frame is ACK: done (ACK wins). Otherwise timeout action next cycle.
//  done and fail are never asserted together; neither asserts while ready=1.
//  tx is a registered output: no glitches, changes only on bit boundaries.
// CONFIGURATION
//  UART_ACK_TX_STATS_EN defined: adds output port
//   attempts_out [$clog2(RETRANSMIT_COUNT+2)-1:0] = frames sent in the current/last transfer.
//   Holds its value after done/fail until the next accepted start; 0 after reset.
//  Undefined: port and logic are absent; attempt counter is internal only.
// TESTING  (defaults: 217 clk/bit, frame 2170 clk, timeout 50000 clk)
//  1 Send 0xA5; bench returns 0xCC 100 clk after stop.
//    -> tx bits 0,1,0,1,0,0,1,0,1,1 at 217-clk spacing; one done pulse; ready=1 next cycle.
//  2 Send 0x3C; no ACK -> exactly 6 identical frames, each followed by a 50000-clk wait.
//    -> one fail pulse after the 6th timeout; no done.
//  3 Send 0x5A; bench sends 0x33 then 0xCC inside the window -> 0x33 ignored; done;
//    single frame only.
//  4 Send 0x01; ACK only after first timeout, 200 clk into the 2nd wait
//    -> 2 frames, done (attempts_out=2 with macro).
//  5 start=1 with 0x11 mid-frame -> ignored.
//    rst=1 during DATA bit 3 -> tx=1, ready=1 next cycle; no pulses.
//  6 ACK frame straddling timeout expiry -> done, no retransmit.
//    5-clk rx glitch low -> no frame decoded.

Source files
------------

// File: rtl/uart_ack_transmitter_if.sv
// Control handshake between the ext-com controller (master) and the
// UART ACK transmitter (slave).
interface uart_ack_transmitter_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  start;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  ready;
   logic                  done;
   logic                  fail;

   modport master (output start, data_in, input  ready, done, fail);
   modport slave  (input  start, data_in, output ready, done, fail);
endinterface

// File: rtl/uart_ack_transmitter.sv
// UART sender with ACK wait and timed retransmission; reports done on ACK or fail on exhaustion.
// Optional UART_ACK_TX_STATS_EN exposes the frame count of the current/last transfer as attempts_out.
module uart_ack_transmitter #(
   parameter int                    CLK_FREQ         = 50_000_000,
   parameter int                    BAUD_RATE        = 230400,
   parameter int                    DATA_WIDTH       = 8,
   parameter int                    RETRANSMIT_COUNT = 5,
   parameter int                    ACK_TIMEOUT      = 1,
   parameter logic [DATA_WIDTH-1:0] ACK_BYTE         = 8'b11001100
) (
   input  logic                   clk,
   input  logic                   rst,
   uart_ack_transmitter_if.slave  ctl,
   output logic                   tx,
   input  logic                   rx
`ifdef UART_ACK_TX_STATS_EN
   ,
   output logic [$clog2(RETRANSMIT_COUNT+2)-1:0] attempts_out
`endif
);

   localparam int CPB   = CLK_FREQ / BAUD_RATE;
   localparam int HALF  = CPB / 2;
   localparam int TMO   = CLK_FREQ / 1000 * ACK_TIMEOUT;
   localparam int BIT_W = $clog2(CPB);
   localparam int TMO_W = $clog2(TMO);
   localparam int IDX_W = $clog2(DATA_WIDTH);
   localparam int ATT_W = $clog2(RETRANSMIT_COUNT + 2);

   typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_STOP, T_WAIT, T_DONE, T_FAIL} tx_state_t;
   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

   tx_state_t             t_state, t_state_n;
   logic [BIT_W-1:0]      t_cnt, t_cnt_n;
   logic [IDX_W-1:0]      t_idx, t_idx_n;
   logic [DATA_WIDTH-1:0] data_q, data_n;
   logic [ATT_W-1:0]      attempts, att_n;
   logic [TMO_W-1:0]      tmo_cnt, tmo_n;
   logic                  tx_n;

   rx_state_t             r_state, r_state_n;
   logic [BIT_W-1:0]      r_cnt, r_cnt_n;
   logic [IDX_W-1:0]      r_idx, r_idx_n;
   logic [DATA_WIDTH-1:0] r_shift, r_shift_n;
   logic                  rx_ack, rx_ack_n;
   logic                  rx_s1, rx_s2, rx_s3;

   logic t_bit_end, r_bit_end, tmo_hit, rx_en, rx_idle;

   assign t_bit_end = (t_cnt == BIT_W'(CPB - 1));
   assign r_bit_end = (r_cnt == BIT_W'(CPB - 1));
   assign tmo_hit   = (tmo_cnt == TMO_W'(TMO - 1));
   assign rx_en     = (t_state == T_WAIT);
   assign rx_idle   = (r_state == R_IDLE);

   assign ctl.ready = (t_state == T_IDLE);
   assign ctl.done  = (t_state == T_DONE);
   assign ctl.fail  = (t_state == T_FAIL);

   // The timeout counter saturates at its last value, so an expiry seen
   // mid-frame stays pending until the receiver returns to idle.
   always_comb begin
      t_state_n = t_state;
      t_cnt_n   = t_cnt;
      t_idx_n   = t_idx;
      data_n    = data_q;
      att_n     = attempts;
      tmo_n     = tmo_cnt;
      case (t_state)
         T_IDLE: if (ctl.start) begin
            t_state_n = T_START;
            data_n    = ctl.data_in;
            att_n     = '0;
            t_cnt_n   = '0;
         end
         T_START: begin
            t_cnt_n = t_cnt + 1'b1;
            if (t_bit_end) begin
               t_cnt_n   = '0;
               t_idx_n   = '0;
               t_state_n = T_DATA;
            end
         end
         T_DATA: begin
            t_cnt_n = t_cnt + 1'b1;
            if (t_bit_end) begin
               t_cnt_n = '0;
               if (t_idx == IDX_W'(DATA_WIDTH - 1)) t_state_n = T_STOP;
               else                                 t_idx_n   = t_idx + 1'b1;
            end
         end
         T_STOP: begin
            t_cnt_n = t_cnt + 1'b1;
            if (t_bit_end) begin
               t_cnt_n   = '0;
               att_n     = attempts + 1'b1;
               tmo_n     = '0;
               t_state_n = T_WAIT;
            end
         end
         T_WAIT: begin
            if (rx_ack) t_state_n = T_DONE;
            else if (tmo_hit) begin
               if (rx_idle) begin
                  if (attempts <= ATT_W'(RETRANSMIT_COUNT)) begin
                     t_state_n = T_START;
                     t_cnt_n   = '0;
                  end else begin
                     t_state_n = T_FAIL;
                  end
               end
            end else begin
               tmo_n = tmo_cnt + 1'b1;
            end
         end
         T_DONE:  t_state_n = T_IDLE;
         T_FAIL:  t_state_n = T_IDLE;
         default: t_state_n = T_IDLE;
      endcase

      tx_n = 1'b1;
      if (t_state_n == T_START)     tx_n = 1'b0;
      else if (t_state_n == T_DATA) tx_n = data_q[t_idx_n];
   end

   // Receiver is held idle outside the ACK window so stray traffic never decodes.
   always_comb begin
      r_state_n = r_state;
      r_cnt_n   = r_cnt;
      r_idx_n   = r_idx;
      r_shift_n = r_shift;
      rx_ack_n  = 1'b0;
      if (!rx_en) begin
         r_state_n = R_IDLE;
      end else begin
         case (r_state)
            R_IDLE: if (rx_s3 && !rx_s2) begin
               r_state_n = R_START;
               r_cnt_n   = '0;
            end
            R_START: begin
               r_cnt_n = r_cnt + 1'b1;
               if (r_cnt == BIT_W'(HALF - 1)) begin
                  r_cnt_n = '0;
                  r_idx_n = '0;
                  r_state_n = rx_s2 ? R_IDLE : R_DATA;
               end
            end
            R_DATA: begin
               r_cnt_n = r_cnt + 1'b1;
               if (r_bit_end) begin
                  r_cnt_n   = '0;
                  r_shift_n = {rx_s2, r_shift[DATA_WIDTH-1:1]};
                  if (r_idx == IDX_W'(DATA_WIDTH - 1)) r_state_n = R_STOP;
                  else                                 r_idx_n   = r_idx + 1'b1;
               end
            end
            R_STOP: begin
               r_cnt_n = r_cnt + 1'b1;
               if (r_bit_end) begin
                  r_cnt_n   = '0;
                  r_state_n = R_IDLE;
                  rx_ack_n  = rx_s2 && (r_shift == ACK_BYTE);
               end
            end
            default: r_state_n = R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         t_state  <= T_IDLE;
         t_cnt    <= '0;
         t_idx    <= '0;
         data_q   <= '0;
         attempts <= '0;
         tmo_cnt  <= '0;
         tx       <= 1'b1;
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_s3    <= 1'b1;
         r_state  <= R_IDLE;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_shift  <= '0;
         rx_ack   <= 1'b0;
      end else begin
         t_state  <= t_state_n;
         t_cnt    <= t_cnt_n;
         t_idx    <= t_idx_n;
         data_q   <= data_n;
         attempts <= att_n;
         tmo_cnt  <= tmo_n;
         tx       <= tx_n;
         rx_s1    <= rx;
         rx_s2    <= rx_s1;
         rx_s3    <= rx_s2;
         r_state  <= r_state_n;
         r_cnt    <= r_cnt_n;
         r_idx    <= r_idx_n;
         r_shift  <= r_shift_n;
         rx_ack   <= rx_ack_n;
      end
   end

`ifdef UART_ACK_TX_STATS_EN
   assign attempts_out = attempts;
`else
`endif

endmodule

// File: tb/tb_uart_ack_transmitter.sv
// Directed bench for uart_ack_transmitter at 16 clk/bit and a 1600-clk ACK window.
`timescale 1ns/1ps
module tb_uart_ack_transmitter;
   localparam int CPB   = 16;
   localparam int TMO   = 1600;
   localparam int FRAME = 10 * CPB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;
   logic tx;
   uart_ack_transmitter_if #(.DATA_WIDTH(8)) ctl();
`ifdef UART_ACK_TX_STATS_EN
   logic [2:0] attempts_out;
`endif

   uart_ack_transmitter #(
      .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
      .RETRANSMIT_COUNT(5), .ACK_TIMEOUT(1), .ACK_BYTE(8'hCC)
   ) dut (
      .clk(clk), .rst(rst), .ctl(ctl), .tx(tx), .rx(rx)
`ifdef UART_ACK_TX_STATS_EN
      , .attempts_out(attempts_out)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0, n_tests = 0, n_fail = 0;
   int n_done = 0, n_failp = 0, n_bad = 0, tx_low_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ctl.done) n_done <= n_done + 1;
      if (ctl.fail) n_failp <= n_failp + 1;
      if ((ctl.done && ctl.fail) || ((ctl.done || ctl.fail) && ctl.ready)) n_bad <= n_bad + 1;
      if (tx == 1'b0) tx_low_cnt <= tx_low_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_word(input logic [7:0] d);
      @(negedge clk);
      ctl.start = 1'b1;
      ctl.data_in = d;
      @(negedge clk);
      ctl.start = 1'b0;
      ctl.data_in = ~d;
   endtask

   // Waits for a start bit, then samples every bit at its centre: f[0]=start, f[9]=stop.
   task automatic get_frame(output logic [9:0] f, output int t0);
      int n = 0;
      f = '1;
      t0 = cyc;
      while (tx !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (tx !== 1'b0) begin
         chk("frame_start_timeout", 0, 1);
         return;
      end
      t0 = cyc;
      repeat (CPB/2) @(negedge clk);
      f[0] = tx;
      for (int i = 1; i < 10; i++) begin
         repeat (CPB) @(negedge clk);
         f[i] = tx;
      end
   endtask

   task automatic send_rx(input logic [7:0] b);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic wait_pulse(input int bound, output bit d, output bit fl, output int t);
      int n = 0;
      d = 0;
      fl = 0;
      t = cyc;
      do begin
         @(negedge clk);
         n++;
      end while (!(ctl.done || ctl.fail) && n < bound);
      if (!(ctl.done || ctl.fail)) begin
         chk("pulse_timeout", 0, 1);
         return;
      end
      d = ctl.done;
      fl = ctl.fail;
      t = cyc;
      chk("busy_during_pulse", ctl.ready, 0);
      @(negedge clk);
      chk("ready_after_pulse", ctl.ready, 1);
      chk("pulse_one_cycle", ctl.done | ctl.fail, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] f;
      int t0, t1, t, snap_low, snap_d, snap_f;
      bit d, fl;
      ctl.start = 1'b0;
      ctl.data_in = '0;

      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_ready", ctl.ready, 1);
      chk("rst_done", ctl.done, 0);
      chk("rst_fail", ctl.fail, 0);
`ifdef UART_ACK_TX_STATS_EN
      chk("rst_attempts", attempts_out, 0);
`endif
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // 1: single frame, ACK 100 clk after stop
      send_word(8'hA5);
      get_frame(f, t0);
      chk("t1_frame", f, {1'b1, 8'hA5, 1'b0});
      snap_low = tx_low_cnt;
      repeat (8 + 100) @(negedge clk);
      fork
         send_rx(8'hCC);
         wait_pulse(400, d, fl, t);
      join
      chk("t1_done", d, 1);
      chk("t1_nofail", fl, 0);
      chk("t1_one_frame", tx_low_cnt - snap_low, 0);
`ifdef UART_ACK_TX_STATS_EN
      chk("t1_attempts", attempts_out, 1);
`endif

      // 2: no ACK -> six identical frames, then fail
      snap_d = n_done;
      snap_f = n_failp;
      send_word(8'h3C);
      for (int i = 0; i < 6; i++) begin
         get_frame(f, t1);
         chk($sformatf("t2_frame%0d", i), f, {1'b1, 8'h3C, 1'b0});
         if (i > 0) chk($sformatf("t2_gap%0d", i), t1 - t0, FRAME + TMO);
         t0 = t1;
      end
      snap_low = tx_low_cnt;
      wait_pulse(TMO + 200, d, fl, t);
      chk("t2_fail", fl, 1);
      chk("t2_nodone", d, 0);
      chk("t2_fail_time", (t - t0 >= FRAME + TMO - 1) && (t - t0 <= FRAME + TMO + 1), 1);
`ifdef UART_ACK_TX_STATS_EN
      chk("t2_attempts", attempts_out, 6);
`endif
      repeat (TMO + FRAME + 100) @(negedge clk);
      chk("t2_no_7th_frame", tx_low_cnt - snap_low, 0);
      chk("t2_done_cnt", n_done - snap_d, 0);
      chk("t2_fail_cnt", n_failp - snap_f, 1);

      // 3: wrong payload ignored, then ACK
      send_word(8'h5A);
      get_frame(f, t0);
      chk("t3_frame", f, {1'b1, 8'h5A, 1'b0});
      snap_low = tx_low_cnt;
      fork
         begin
            repeat (20) @(negedge clk);
            send_rx(8'h33);
            repeat (20) @(negedge clk);
            send_rx(8'hCC);
         end
         wait_pulse(800, d, fl, t);
      join
      chk("t3_done", d, 1);
      chk("t3_not_on_33", t - t0 > 400, 1);
      chk("t3_single_frame", tx_low_cnt - snap_low, 0);

      // 4: ACK 200 clk into the second window
      send_word(8'h01);
      get_frame(f, t0);
      chk("t4_frame1", f, {1'b1, 8'h01, 1'b0});
      get_frame(f, t1);
      chk("t4_frame2", f, {1'b1, 8'h01, 1'b0});
      chk("t4_gap", t1 - t0, FRAME + TMO);
      repeat (8 + 200) @(negedge clk);
      fork
         send_rx(8'hCC);
         wait_pulse(400, d, fl, t);
      join
      chk("t4_done", d, 1);
`ifdef UART_ACK_TX_STATS_EN
      chk("t4_attempts", attempts_out, 2);
`endif

      // 5a: start mid-frame is ignored
      send_word(8'h22);
      fork
         get_frame(f, t0);
         begin
            repeat (40) @(negedge clk);
            ctl.start = 1'b1;
            ctl.data_in = 8'h11;
            @(negedge clk);
            ctl.start = 1'b0;
         end
      join
      chk("t5_frame_ignores_start", f, {1'b1, 8'h22, 1'b0});
      snap_low = tx_low_cnt;
      repeat (8 + 30) @(negedge clk);
      fork
         send_rx(8'hCC);
         wait_pulse(400, d, fl, t);
      join
      chk("t5_done", d, 1);
      chk("t5_single_frame", tx_low_cnt - snap_low, 0);

      // 5b: reset in the middle of data bit 3
      snap_d = n_done;
      snap_f = n_failp;
      send_word(8'h77);
      repeat (70) @(negedge clk);
      chk("t5_bit3_low", tx, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_rst_tx", tx, 1);
      chk("t5_rst_ready", ctl.ready, 1);
      rst = 1'b0;
      snap_low = tx_low_cnt;
      repeat (TMO + 400) @(negedge clk);
      chk("t5_rst_quiet_tx", tx_low_cnt - snap_low, 0);
      chk("t5_rst_no_done", n_done - snap_d, 0);
      chk("t5_rst_no_fail", n_failp - snap_f, 0);

      // 6a: ACK frame straddling expiry wins
      send_word(8'h44);
      get_frame(f, t0);
      snap_low = tx_low_cnt;
      repeat (FRAME + TMO - 60 - 152) @(negedge clk);
      fork
         send_rx(8'hCC);
         wait_pulse(400, d, fl, t);
      join
      chk("t6a_done", d, 1);
      chk("t6a_nofail", fl, 0);
      chk("t6a_after_expiry", t - t0 > FRAME + TMO, 1);
      chk("t6a_no_retx", tx_low_cnt - snap_low, 0);

      // 6b: non-ACK frame straddling expiry defers the retransmit
      send_word(8'h45);
      get_frame(f, t0);
      repeat (FRAME + TMO - 60 - 152) @(negedge clk);
      fork
         send_rx(8'h33);
         get_frame(f, t1);
      join
      chk("t6b_frame2", f, {1'b1, 8'h45, 1'b0});
      chk("t6b_deferred", (t1 - t0 > FRAME + TMO) && (t1 - t0 < FRAME + TMO + 200), 1);
      repeat (8 + 20) @(negedge clk);
      fork
         send_rx(8'hCC);
         wait_pulse(400, d, fl, t);
      join
      chk("t6b_done", d, 1);

      // 6c: 5-clk glitch just before expiry must not delay the retransmit
      send_word(8'h66);
      get_frame(f, t0);
      repeat (FRAME + TMO - 60 - 152) @(negedge clk);
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      get_frame(f, t1);
      chk("t6c_frame2", f, {1'b1, 8'h66, 1'b0});
      chk("t6c_gap", t1 - t0, FRAME + TMO);
      repeat (8 + 20) @(negedge clk);
      fork
         send_rx(8'hCC);
         wait_pulse(400, d, fl, t);
      join
      chk("t6c_done", d, 1);

      chk("pulse_rules", n_bad, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
